fetch_unit: RTL



---
 rtl/fetch_unit_pkg.sv | 12 +
 rtl/fetch_fifo.sv | 54 +++++
 rtl/fetch_unit.sv | 102 ++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-path constants and the {pc, insn} bundle carried from memory to decode.
package fetch_unit_pkg;
  localparam int unsigned FU_AWIDTH    = 32;
  localparam int unsigned FU_DWIDTH    = 32;
  localparam logic [31:0] BASEADDR_DEF = 32'h0100_0000;
  localparam logic [31:0] PC_INC       = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } fetch_bundle_t;
endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with occupancy count and flush; head is read combinationally.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_full;
  logic             w_push;
  logic             w_pop;

  assign empty  = (r_count == '0);
  assign w_full = (r_count == CW'(DEPTH));
  assign w_pop  = pop & ~empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push = push & (~w_full | w_pop);
  assign rdata  = r_mem[r_rptr];
  assign count  = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[r_wptr] <= wdata;
  end
endmodule

// File: rtl/fetch_unit.sv
// Pipeline front end: owns the fetch PC, issues credit-limited in-order fetches,
// buffers returned words for decode and drops responses made stale by a redirect.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned       AWIDTH   = FU_AWIDTH,
  parameter int unsigned       DWIDTH   = FU_DWIDTH,
  parameter logic [AWIDTH-1:0] BASEADDR = AWIDTH'(BASEADDR_DEF),
  parameter int unsigned       DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_valid_i,
  input  logic [AWIDTH-1:0] redirect_pc_i,
  output logic              imem_req_valid_o,
  input  logic              imem_req_ready_i,
  output logic [AWIDTH-1:0] imem_req_addr_o,
  input  logic              imem_rsp_valid_i,
  input  logic [DWIDTH-1:0] imem_rsp_data_i,
  output logic              insn_valid_o,
  input  logic              insn_ready_i,
  output logic [DWIDTH-1:0] insn_o,
  output logic [AWIDTH-1:0] insn_pc_o
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [AWIDTH-1:0]        r_pc;
  logic [CW-1:0]            r_drop_cnt;
  logic                     r_active;
  logic [CW-1:0]            w_inflight_cnt;
  logic [CW-1:0]            w_fifo_cnt;
  logic [CW:0]              w_occupancy;
  logic                     w_pcq_empty;
  logic                     w_ibuf_empty;
  logic [AWIDTH-1:0]        w_pcq_head;
  logic [AWIDTH+DWIDTH-1:0] w_ibuf_head;
  logic                     w_req_fire;
  logic                     w_rsp_fire;
  logic                     w_rsp_keep;
  logic                     w_insn_pop;

  // Every request reserves a buffer slot, so the instruction FIFO can never overflow.
  assign w_occupancy      = {1'b0, w_inflight_cnt} + {1'b0, w_fifo_cnt};
  assign imem_req_valid_o = r_active & (w_occupancy < (CW+1)'(DEPTH)) & ~redirect_valid_i;
  assign imem_req_addr_o  = r_pc;
  assign w_req_fire       = imem_req_valid_o & imem_req_ready_i;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign w_rsp_fire = imem_rsp_valid_i & ~w_pcq_empty;
  assign w_rsp_keep = w_rsp_fire & (r_drop_cnt == '0) & ~redirect_valid_i;

  assign insn_valid_o = ~w_ibuf_empty & ~redirect_valid_i;
  assign w_insn_pop   = insn_valid_o & insn_ready_i;
  assign insn_pc_o    = w_ibuf_empty ? '0 : w_ibuf_head[AWIDTH+DWIDTH-1:DWIDTH];
  assign insn_o       = w_ibuf_empty ? '0 : w_ibuf_head[DWIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= BASEADDR;
      r_drop_cnt <= '0;
      r_active   <= 1'b0;
    end else begin
      r_active <= 1'b1;
      if (redirect_valid_i) begin
        r_pc       <= {redirect_pc_i[AWIDTH-1:2], 2'b00};
        r_drop_cnt <= w_inflight_cnt - CW'(w_rsp_fire);
      end else begin
        if (w_req_fire) r_pc <= r_pc + AWIDTH'(PC_INC);
        if (w_rsp_fire && r_drop_cnt != '0) r_drop_cnt <= r_drop_cnt - CW'(1);
      end
    end
  end

  // Stale entries stay queued so late responses still pop their PC in order.
  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(AWIDTH)) u_pc_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_req_fire),
    .pop   (w_rsp_fire),
    .flush (1'b0),
    .wdata (r_pc),
    .rdata (w_pcq_head),
    .count (w_inflight_cnt),
    .empty (w_pcq_empty)
  );

  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(AWIDTH+DWIDTH)) u_insn_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_rsp_keep),
    .pop   (w_insn_pop),
    .flush (redirect_valid_i),
    .wdata ({w_pcq_head, imem_rsp_data_i}),
    .rdata (w_ibuf_head),
    .count (w_fifo_cnt),
    .empty (w_ibuf_empty)
  );

  a_rsp_without_request: assert property (
    @(posedge clk) disable iff (!rst_n) imem_rsp_valid_i |-> !w_pcq_empty
  );
endmodule
